spi_slave_shift: RTL and testbench

- SPI responder (slave) shift engine: the far end of the SPI master and baud rate generator link, for loopback and for the slave side of the block.
- Clocked entirely by PCLK. sclk, ss and mosi are asynchronous inputs, synchronised and edge-detected in the PCLK domain.
- Supports all four CPOL/CPHA modes, MSB first.
- Provides a one-entry TX holding buffer (valid/ready) and a level-held RX data register with acknowledge.

---
 rtl/spi_slave_shift.sv | 190 +++++++++++++++++++
 tb/tb_spi_slave_shift.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_shift.sv
// SPI responder shift engine, fully PCLK-synchronous, all CPOL/CPHA modes, MSB first.
// Optional define SPI_SLAVE_OVR_EN adds a sticky rx_ovr overrun flag.
`timescale 1ns/1ps

module spi_slave_shift #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  spe,
    input  logic                  cpol,
    input  logic                  cphase,
    input  logic                  ss_in,
    input  logic                  sclk_in,
    input  logic                  mosi_in,
    output logic                  miso_out,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ack,
`ifdef SPI_SLAVE_OVR_EN
    output logic                  rx_ovr,
`endif
    output logic                  busy
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] ss_sync_q, sclk_sync_q, mosi_sync_q;
    logic                   ss_d_q, sclk_d_q;
    logic                   cpol_q, cpha_q;
    logic [DATA_WIDTH-1:0]  shift_q, tx_buf_q, rx_data_q;
    logic                   tx_full_q, rx_valid_q;
    logic [CntW-1:0]        bit_cnt_q;
    logic                   sample_q, reload_q, frame_done_q;

    logic ss_s, sclk_s, mosi_s;
    logic active, start, stop;
    logic sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
    logic load, shift;

    assign ss_s   = ss_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Synchronised sclk idles at cpol so no spurious edge is seen out of reset.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ss_sync_q   <= '0;
            sclk_sync_q <= {SYNC_STAGES{cpol}};
            mosi_sync_q <= '0;
            ss_d_q      <= 1'b0;
            sclk_d_q    <= cpol;
        end else begin
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_in};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
            ss_d_q      <= ss_s;
            sclk_d_q    <= sclk_s;
        end
    end

    // Mode is frozen for the duration of a frame.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
        end else if (state_q == StIdle) begin
            cpol_q <= cpol;
            cpha_q <= cphase;
        end
    end

    assign sclk_edge   = sclk_s ^ sclk_d_q;
    assign lead_edge   = sclk_edge && (sclk_d_q == cpol_q);
    assign trail_edge  = sclk_edge && (sclk_s == cpol_q);
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;

    assign active = (state_q == StActive);
    assign start  = (state_q == StIdle) && spe && !ss_s && ss_d_q;
    assign stop   = active && (!spe || ss_s);
    assign load   = (start && !cphase) || (active && !stop && shift_edge && reload_q);
    assign shift  = active && !stop && shift_edge && !reload_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state_q <= StIdle;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StActive;
            StActive: if (stop)  state_d = StIdle;
            default:             state_d = StIdle;
        endcase
    end

    always_comb begin
        busy     = active;
        miso_oe  = active;
        miso_out = active & shift_q[DATA_WIDTH-1];
        tx_ready = !tx_full_q;
        rx_data  = rx_data_q;
        rx_valid = rx_valid_q;
    end

    // TX holding buffer; an empty buffer at load time sends zeros.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_buf_q  <= '0;
            tx_full_q <= 1'b0;
        end else if (tx_valid && !tx_full_q) begin
            tx_buf_q  <= tx_data;
            tx_full_q <= 1'b1;
        end else if (load) begin
            tx_full_q <= 1'b0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            shift_q <= '0;
        end else if (load) begin
            shift_q <= tx_full_q ? tx_buf_q : '0;
        end else if (shift) begin
            shift_q <= {shift_q[DATA_WIDTH-2:0], sample_q};
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            bit_cnt_q    <= '0;
            sample_q     <= 1'b0;
            reload_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (start) begin
                bit_cnt_q <= '0;
                reload_q  <= cphase;
            end else if (stop) begin
                bit_cnt_q <= '0;
                reload_q  <= 1'b0;
            end else if (active) begin
                if (sample_edge) begin
                    sample_q     <= mosi_s;
                    bit_cnt_q    <= bit_cnt_q + CntW'(1);
                    frame_done_q <= (bit_cnt_q == CntW'(DATA_WIDTH - 1));
                end
                if (frame_done_q) begin
                    bit_cnt_q <= '0;
                    reload_q  <= 1'b1;
                end
                if (load) reload_q <= 1'b0;
            end
        end
    end

    // A new frame setting rx_valid takes priority over a same-cycle ack.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else if (frame_done_q) begin
            rx_data_q  <= {shift_q[DATA_WIDTH-2:0], sample_q};
            rx_valid_q <= 1'b1;
        end else if (rx_ack) begin
            rx_valid_q <= 1'b0;
        end
    end

`ifdef SPI_SLAVE_OVR_EN
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)                      rx_ovr <= 1'b0;
        else if (frame_done_q && rx_valid_q) rx_ovr <= 1'b1;
        else if (rx_ack)                   rx_ovr <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_spi_slave_shift.sv
// Scoreboard bench for spi_slave_shift: bench acts as SPI master, monitor checks rx frames.
`timescale 1ns/1ps

module tb_spi_slave_shift;

    localparam int HALF = 4;

    logic       PCLK, PRESETn, spe, cpol, cphase, ss_in, sclk_in, mosi_in;
    logic       miso_out, miso_oe, tx_valid, tx_ready, rx_valid, rx_ack, busy;
    logic [7:0] tx_data, rx_data;
`ifdef SPI_SLAVE_OVR_EN
    logic       rx_ovr;
`endif

    spi_slave_shift #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .spe      (spe),
        .cpol     (cpol),
        .cphase   (cphase),
        .ss_in    (ss_in),
        .sclk_in  (sclk_in),
        .mosi_in  (mosi_in),
        .miso_out (miso_out),
        .miso_oe  (miso_oe),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ack   (rx_ack),
`ifdef SPI_SLAVE_OVR_EN
        .rx_ovr   (rx_ovr),
`endif
        .busy     (busy)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    logic       rx_valid_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every new rx_valid must match the oldest expected frame.
    always @(negedge PCLK) begin
        logic [7:0] e;
        if (rx_valid === 1'b1 && rx_valid_prev !== 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rx_unexpected: got rx_data=%0h, expected no frame", rx_data);
            end else begin
                e = exp_q.pop_front();
                if (rx_data !== e) begin
                    n_fail++;
                    $display("FAIL rx_data: got %0h, expected %0h", rx_data, e);
                end
            end
        end
        rx_valid_prev = rx_valid;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic push_tx(input logic [7:0] b);
        int k = 0;
        while (!tx_ready && k < 200) begin cyc(1); k++; end
        check("tx_ready_before_push", 32'(tx_ready), 32'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
    endtask

    task automatic frame(input logic [7:0] mo, input int nbits, input logic cp, input logic cph,
                         output logic [7:0] mi);
        logic [7:0] acc = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!cph) begin
                mosi_in = mo[7-i];
                cyc(HALF);
                acc     = {acc[6:0], miso_out};
                sclk_in = !cp;
                cyc(HALF);
                sclk_in = cp;
            end else begin
                cyc(HALF);
                sclk_in = !cp;
                mosi_in = mo[7-i];
                cyc(HALF);
                acc     = {acc[6:0], miso_out};
                sclk_in = cp;
            end
        end
        cyc(HALF);
        mi = acc;
    endtask

    task automatic wait_rx(input bit do_ack);
        int k = 0;
        while (!rx_valid && k < 100) begin cyc(1); k++; end
        check("rx_valid_rise", 32'(rx_valid), 32'd1);
        if (do_ack) begin
            rx_ack = 1'b1;
            cyc(1);
            rx_ack = 1'b0;
            cyc(1);
            check("rx_valid_clear", 32'(rx_valid), 32'd0);
        end
    endtask

    task automatic ss_low();
        ss_in = 1'b0;
        cyc(8);
    endtask

    task automatic ss_high();
        ss_in = 1'b1;
        cyc(8);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no end of test, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] got;
        PRESETn = 1'b0; spe = 1'b1; cpol = 1'b0; cphase = 1'b0;
        ss_in = 1'b1; sclk_in = 1'b0; mosi_in = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0; rx_ack = 1'b0;
        cyc(3);
        check("rst_miso_out", 32'(miso_out), 32'd0);
        check("rst_miso_oe",  32'(miso_oe),  32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_data",  32'(rx_data),  32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        PRESETn = 1'b1;
        cyc(5);

        // Mode 0, preloaded A5, master sends 3C.
        push_tx(8'hA5);
        check("m0_tx_ready_low", 32'(tx_ready), 32'd0);
        exp_q.push_back(8'h3C);
        ss_low();
        check("m0_busy", 32'(busy), 32'd1);
        check("m0_miso_oe", 32'(miso_oe), 32'd1);
        check("m0_tx_ready_high", 32'(tx_ready), 32'd1);
        frame(8'h3C, 8, 1'b0, 1'b0, got);
        check("m0_miso_byte", 32'(got), 32'hA5);
        wait_rx(1'b1);
        ss_high();
        check("m0_miso_oe_off", 32'(miso_oe), 32'd0);
        check("m0_busy_off", 32'(busy), 32'd0);

        // Mode 3, tx 81, master sends F0.
        cpol = 1'b1; cphase = 1'b1; sclk_in = 1'b1;
        cyc(6);
        push_tx(8'h81);
        exp_q.push_back(8'hF0);
        ss_low();
        check("m3_miso_oe", 32'(miso_oe), 32'd1);
        frame(8'hF0, 8, 1'b1, 1'b1, got);
        check("m3_miso_byte", 32'(got), 32'h81);
        wait_rx(1'b1);
        ss_high();
        check("m3_miso_oe_off", 32'(miso_oe), 32'd0);

        // Back-to-back frames with ss held low.
        cpol = 1'b0; cphase = 1'b0; sclk_in = 1'b0;
        cyc(6);
        push_tx(8'h12);
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        ss_low();
        push_tx(8'h34);
        check("b2b_tx_ready_low", 32'(tx_ready), 32'd0);
        frame(8'hAA, 8, 1'b0, 1'b0, got);
        check("b2b_miso_byte1", 32'(got), 32'h12);
        wait_rx(1'b1);
        frame(8'h55, 8, 1'b0, 1'b0, got);
        check("b2b_miso_byte2", 32'(got), 32'h34);
        wait_rx(1'b1);
        ss_high();

        // Underrun in mode 1.
        cphase = 1'b1;
        cyc(6);
        check("ur_tx_ready", 32'(tx_ready), 32'd1);
        exp_q.push_back(8'hFF);
        ss_low();
        frame(8'hFF, 8, 1'b0, 1'b1, got);
        check("ur_miso_byte", 32'(got), 32'h00);
        wait_rx(1'b1);
        ss_high();

        // Abort after 5 bits; buffered byte survives into the next frame.
        cphase = 1'b0;
        cyc(6);
        ss_low();
        push_tx(8'hC3);
        frame(8'hA0, 5, 1'b0, 1'b0, got);
        ss_high();
        check("ab_rx_valid", 32'(rx_valid), 32'd0);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_tx_retained", 32'(tx_ready), 32'd0);
        cyc(20);
        exp_q.push_back(8'h0F);
        ss_low();
        check("ab_tx_loaded", 32'(tx_ready), 32'd1);
        frame(8'h0F, 8, 1'b0, 1'b0, got);
        check("ab_miso_byte", 32'(got), 32'hC3);
        wait_rx(1'b1);
        ss_high();

`ifdef SPI_SLAVE_OVR_EN
        // Two frames without ack raise the overrun flag.
        exp_q.push_back(8'h11);
        ss_low();
        frame(8'h11, 8, 1'b0, 1'b0, got);
        wait_rx(1'b0);
        frame(8'h22, 8, 1'b0, 1'b0, got);
        cyc(4);
        check("ovr_rx_data", 32'(rx_data), 32'h22);
        check("ovr_rx_valid", 32'(rx_valid), 32'd1);
        check("ovr_flag", 32'(rx_ovr), 32'd1);
        rx_ack = 1'b1;
        cyc(1);
        rx_ack = 1'b0;
        cyc(1);
        check("ovr_valid_clear", 32'(rx_valid), 32'd0);
        check("ovr_flag_clear", 32'(rx_ovr), 32'd0);
        ss_high();
`endif

        cyc(10);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
